// File: rtl/conv_kernel_loader.sv
// ============================================================================
// Module   : conv_kernel_loader
// Purpose  : Streams kernel words into the conv weight RAM write port and
//            reports completion, word count and a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_kernel_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_words;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_error;

  logic w_len_ok;
  logic w_accept;
  logic w_reject;
  logic w_hs;
  logic w_last;

  assign w_len_ok = (length != '0) && (length <= c_DEPTH);
  assign w_accept = (r_state == c_IDLE) && start && w_len_ok;
  assign w_reject = (r_state == c_IDLE) && start && !w_len_ok;
  assign w_hs     = in_valid && in_ready;
  assign w_last   = (r_words == (r_len - c_CNT_ONE));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_state_next = c_LOAD;
      c_LOAD: if (w_hs && w_last) w_state_next = c_DONE;
      c_DONE: w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // State-decoded outputs; in_ready deliberately ignores in_valid
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      c_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      c_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: one-cycle registered write port and upload statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_addr     <= '0;
      r_words    <= '0;
      r_checksum <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_wr_en <= w_hs;
      r_error <= w_reject;
      if (w_accept) begin
        r_len      <= length;
        r_addr     <= base_addr;
        r_words    <= '0;
        r_checksum <= '0;
      end else if (w_hs) begin
        r_wr_addr  <= r_addr;
        r_wr_data  <= in_data;
        // Address wraps naturally because DEPTH is a power of two
        r_addr     <= r_addr + c_ADDR_ONE;
        r_words    <= r_words + c_CNT_ONE;
        r_checksum <= r_checksum + in_data;
      end
    end
  end

  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign error         = r_error;
  assign words_written = r_words;
  assign checksum      = r_checksum;

endmodule

`default_nettype wire

// File: doc/conv_kernel_loader.md
Name: conv_kernel_loader

Overview:
Write-side controller that fills the 64-entry x 16-bit convolution kernel weight memories. Host software streams kernel words in over a valid/ready interface. The block generates sequential write addresses and wr_en/wr_data for a single RAM write port. It reports completion, a word count and a running checksum so software can confirm the upload before the conv engine reads the weights back through its read ports.

Parameters:
DATA_WIDTH, 16, width of one kernel word
ADDR_WIDTH, 6, kernel memory address width
DEPTH, 64, number of kernel memory entries (must equal 2**ADDR_WIDTH)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first write address, latched on accepted start
length  input  ADDR_WIDTH+1  number of words to load, valid range 1..DEPTH, latched on accepted start
in_data  input  DATA_WIDTH  incoming kernel word
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept in_data this cycle
wr_en  output  1  memory write strobe
wr_addr  output  ADDR_WIDTH  memory write address
wr_data  output  DATA_WIDTH  memory write data
busy  output  1  high in LOAD
done  output  1  one-cycle pulse when the final word is written
error  output  1  one-cycle pulse when start is rejected for an illegal length
words_written  output  ADDR_WIDTH+1  words accepted in current or last load
checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of words accepted in current or last load

Behaviour:
- Reset (async, any state): state=IDLE; in_ready, wr_en, busy, done and error = 0; wr_addr, wr_data, words_written and checksum = 0; latched base and length cleared. An in-flight load is abandoned. No write occurs after reset asserts.
- FSM states: IDLE, LOAD, DONE.
- IDLE: start with 1<=length<=DEPTH -> LOAD. On that edge: latch base and length; words_written=0; checksum=0; internal addr=base_addr.
- IDLE: start with length==0 or length>DEPTH -> error pulses the following cycle; stay IDLE; words_written and checksum unchanged.
- LOAD: in_ready=1 (decoded from state, no dependency on in_valid). busy=1.
- Handshake: in_valid & in_ready at a rising edge. On that edge: wr_en<=1; wr_addr<=addr; wr_data<=in_data; addr<=addr+1, wrapping modulo DEPTH (base 62, length 4 writes 62, 63, 0, 1); words_written+1; checksum+in_data with carry discarded.
- Write latency: write appears on the port exactly 1 cycle after its handshake. wr_en is low in any cycle not following a handshake. Throughput is 1 word/cycle with no bubbles.
- in_valid low in LOAD: no write, counters hold, stay in LOAD indefinitely.
- Last word (words_written reaches length-1 before the handshake): next state is DONE. During the DONE cycle: wr_en=1 for the last word, done=1, busy=0, in_ready=0. DONE -> IDLE unconditionally next cycle.
- start is ignored in LOAD and in DONE: no error, no relatch.
- start in the IDLE cycle immediately after DONE is accepted normally.
- words_written and checksum hold their final values in IDLE until the next accepted start.
- in_valid/in_data presented outside LOAD are not consumed and not written.
- DEPTH-length load starting at nonzero base writes every entry exactly once, wrapping through 0.

Test Plan:
- Reset, then start base=0 length=64, stream words 0x0001..0x0040 back-to-back -> 64 consecutive wr_en cycles with addr 0..63 and data 0x0001..0x0040. done is high with the final write. words_written=64, checksum=0x0820. No bubbles.
- Start base=62 length=4, data 0xFFFF,0x0002,0x0003,0x0004 -> writes at addrs 62, 63, 0, 1. checksum=0x0008 (wraps). done once.
- Start with length=0, and separately length=65 -> error pulse 1 cycle; busy stays 0. No writes. Prior words_written/checksum retained.
- Load length=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, each one cycle after its handshake. wr_en low in gap cycles. start asserted mid-load is ignored.
- Assert reset after 2 of 5 words accepted -> all outputs 0 asynchronously, no further wr_en. A new start base=10 length=1 then completes normally with a write to addr 10.
- start in the cycle right after done -> accepted; in_ready rises the next cycle.
